// File: rtl/cgra_dma_pkg.sv
// Shared types for the CGRA DMA copy engine: FSM state, word geometry and latched config.
package cgra_dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } dma_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int CFG_ADDR_WIDTH     = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int WORD_SHIFT         = $clog2(BYTES_PER_WORD);

    // Config captured on an accepted start; held constant for the whole transfer.
    typedef struct packed {
        logic [CFG_ADDR_WIDTH-1:0] src;
        logic [CFG_ADDR_WIDTH-1:0] dst;
        logic [31:0]               nwords;
    } dma_cfg_t;

endpackage

// File: rtl/cgra_dma_if.sv
// Bundle between the DMA engine, the CSR block (config/status) and the memory interconnect.
interface cgra_dma_if
    import cgra_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a request (rd_req/wr_req) with its address/data stays high and stable
    // until the matching gnt is seen on a rising edge; one grant per cycle. Read data
    // returns on rd_rvalid strictly in request order; wr_gnt means the write is complete.
    logic [ADDR_WIDTH-1:0] dma_src;
    logic [ADDR_WIDTH-1:0] dma_dst;
    logic [31:0]           dma_size;
    logic                  dma_start;
    logic                  dma_busy;
    logic                  dma_done;
    logic                  dma_err;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_rvalid;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_wdata;
    logic                  wr_gnt;
    dma_state_e            dbg_state;

    modport master (
        input  dma_src, dma_dst, dma_size, dma_start,
        output dma_busy, dma_done, dma_err,
        output rd_req, rd_addr,
        input  rd_gnt, rd_rvalid, rd_rdata,
        output wr_req, wr_addr, wr_wdata,
        input  wr_gnt,
        output dbg_state
    );

    modport slave (
        output dma_src, dma_dst, dma_size, dma_start,
        input  dma_busy, dma_done, dma_err,
        input  rd_req, rd_addr,
        output rd_gnt, rd_rvalid, rd_rdata,
        input  wr_req, wr_addr, wr_wdata,
        output wr_gnt,
        input  dbg_state
    );

endinterface

// File: rtl/cgra_dma_fifo.sv
// Synchronous first-word-fall-through FIFO holding read data until it is written out.
module cgra_dma_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/cgra_dma_engine.sv
// Word-granular memory-to-memory copy engine with overlapped reads and writes.
// Optional start-time alignment check is enabled by defining CGRA_DMA_ALIGN_CHECK_EN.
module cgra_dma_engine
    import cgra_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    cgra_dma_if.master bus
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WSHIFT = $clog2(BYTES);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    dma_state_e            state_q, state_d;
    dma_cfg_t              cfg_q, cfg_d;
    logic [31:0]           reads_q, reads_d;
    logic [31:0]           writes_q, writes_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CW:0]           credit_used;
    logic [31:0]           start_nwords;
    logic                  rd_req, wr_req;
    logic                  rd_fire, wr_fire, push;

    assign start_nwords = bus.dma_size >> WSHIFT;
    assign credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign rd_fire      = rd_req & bus.rd_gnt;
    assign wr_fire      = wr_req & bus.wr_gnt;
    // Credits already bound pushes; the full term only keeps a stray rvalid harmless.
    assign push         = bus.rd_rvalid & (state_q == RUN) & ~fifo_full;

`ifdef CGRA_DMA_ALIGN_CHECK_EN
    localparam logic [31:0] SIZE_MASK = 32'(BYTES - 1);
    logic misaligned;
    logic err_q, err_d;

    assign misaligned = ((bus.dma_src  & ~ALIGN_MASK) != '0) ||
                        ((bus.dma_dst  & ~ALIGN_MASK) != '0) ||
                        ((bus.dma_size & SIZE_MASK)   != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`endif

    cgra_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.rd_rdata),
        .pop       (wr_fire),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            reads_q       <= '0;
            writes_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            reads_q       <= reads_d;
            writes_q      <= writes_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        reads_d       = reads_q;
        writes_d      = writes_q;
        outstanding_d = outstanding_q + CW'(rd_fire) - CW'(push);
`ifdef CGRA_DMA_ALIGN_CHECK_EN
        err_d         = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.dma_start) begin
`ifdef CGRA_DMA_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = FINISH;
                        err_d   = 1'b1;
                    end else
`endif
                    if (start_nwords == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d      = RUN;
                        cfg_d.src    = bus.dma_src & ALIGN_MASK;
                        cfg_d.dst    = bus.dma_dst & ALIGN_MASK;
                        cfg_d.nwords = start_nwords;
                        reads_d      = '0;
                        writes_d     = '0;
                    end
                end
            end
            RUN: begin
                if (rd_fire) reads_d = reads_q + 32'd1;
                if (wr_fire) begin
                    writes_d = writes_q + 32'd1;
                    if (writes_q + 32'd1 == cfg_q.nwords) state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses are base plus word index, so they wrap modulo 2^ADDR_WIDTH for free.
    always_comb begin
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (state_q == RUN) begin
            rd_req = (reads_q < cfg_q.nwords) && (credit_used < (CW+1)'(FIFO_DEPTH));
            wr_req = !fifo_empty;
        end
        bus.dma_busy  = (state_q == RUN);
        bus.dma_done  = (state_q == FINISH);
`ifdef CGRA_DMA_ALIGN_CHECK_EN
        bus.dma_err   = err_q;
`else
        bus.dma_err   = 1'b0;
`endif
        bus.rd_req    = rd_req;
        bus.rd_addr   = cfg_q.src + (ADDR_WIDTH'(reads_q) << WSHIFT);
        bus.wr_req    = wr_req;
        bus.wr_addr   = cfg_q.dst + (ADDR_WIDTH'(writes_q) << WSHIFT);
        bus.wr_wdata  = wr_req ? fifo_head : '0;
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_cgra_dma_engine.sv
// Directed bench for cgra_dma_engine: memory responder, negedge monitor, one task per scenario.
module tb_cgra_dma_engine;

    localparam logic [31:0] DKEY = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_gnt_en;
    logic wr_gnt_en;
    int   checks = 0;
    int   errors = 0;

    cgra_dma_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cgra_dma_engine #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rd_gnt = bus.rd_req & rd_gnt_en;
    assign bus.wr_gnt = bus.wr_req & wr_gnt_en;

    // Memory responder: read data is the address xor DKEY, returned one cycle after grant.
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_rvalid <= 1'b0;
            bus.rd_rdata  <= '0;
        end else begin
            bus.rd_rvalid <= pend_v;
            bus.rd_rdata  <= pend_v ? pend_d : '0;
        end
    end

    // Monitor (negedge) records traffic; scenario tasks compare it against expectations.
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int rd_cnt, wr_cnt, done_cnt, err_cnt, busy_cyc, req_seen, max_inflight;

    always @(negedge clk) begin
        pend_v = rst_n && bus.rd_req && bus.rd_gnt;
        pend_d = bus.rd_addr ^ DKEY;
        if (rst_n) begin
            if (bus.rd_req && bus.rd_gnt) begin
                rd_log.push_back(bus.rd_addr);
                rd_cnt++;
            end
            if (bus.wr_req && bus.wr_gnt) begin
                wr_addr_log.push_back(bus.wr_addr);
                wr_data_log.push_back(bus.wr_wdata);
                wr_cnt++;
            end
            if (bus.dma_done) done_cnt++;
            if (bus.dma_err) err_cnt++;
            if (bus.dma_busy) busy_cyc++;
            if (bus.rd_req || bus.wr_req) req_seen++;
            if (rd_cnt - wr_cnt > max_inflight) max_inflight = rd_cnt - wr_cnt;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        busy_cyc = 0; req_seen = 0; max_inflight = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns in cycle T+1, where T is the edge that samples dma_start.
    task automatic do_start(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size);
        @(posedge clk);
        #1;
        clear_logs();
        bus.dma_src   = src;
        bus.dma_dst   = dst;
        bus.dma_size  = size;
        bus.dma_start = 1'b1;
        @(posedge clk);
        #1;
        bus.dma_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            if (bus.dma_done) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        bus.dma_src = '0; bus.dma_dst = '0; bus.dma_size = '0; bus.dma_start = 1'b0;
        rd_gnt_en = 1'b1; wr_gnt_en = 1'b1;
        clear_logs();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        checks++; if (bus.dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.dma_busy); end
        checks++; if (bus.dma_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.dma_done); end
        checks++; if (bus.dma_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.dma_err); end
        checks++; if ({bus.rd_req, bus.wr_req} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b expected 00", {bus.rd_req, bus.wr_req}); end
        checks++; if (bus.rd_addr !== 32'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00000000", bus.rd_addr); end
        checks++; if (bus.wr_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00000000", bus.wr_addr); end
        checks++; if (bus.wr_wdata !== 32'h0) begin errors++; $display("FAIL reset_wr_wdata: got %h expected 00000000", bus.wr_wdata); end
    endtask

    task automatic test_basic_copy();
        logic [31:0] exp_q[$];
        bit ok;
        int n;
        do_start(32'h1000, 32'h2000, 32'd16);
        checks++; if (bus.dma_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %b expected 1", bus.dma_busy); end
        checks++; if (bus.rd_req !== 1'b1) begin errors++; $display("FAIL basic_rd_req_t1: got %b expected 1", bus.rd_req); end
        checks++; if (bus.rd_addr !== 32'h1000) begin errors++; $display("FAIL basic_rd_addr_t1: got %h expected 00001000", bus.rd_addr); end
        wait_done(100, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done expected done within 100 cycles"); end
        checks++; if (n != 6) begin errors++; $display("FAIL basic_done_latency: got %0d expected 6 cycles after T+1", n); end
        checks++; if (bus.dma_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.dma_busy); end
        cycles(1);
        checks++; if (bus.dma_done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", bus.dma_done); end
        cycles(3);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++; if (busy_cyc != 6) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 6", busy_cyc); end
        exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        checks++; if (rd_log.size() != 4 || wr_addr_log.size() != 4) begin errors++; $display("FAIL basic_counts: got rd %0d wr %0d expected 4 4", rd_log.size(), wr_addr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= rd_log.size() || rd_log[i] !== exp_q[i]) begin errors++; $display("FAIL basic_rd_addr[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'hx, exp_q[i]); end
            checks++; if (i >= wr_addr_log.size() || wr_addr_log[i] !== exp_q[i] + 32'h1000) begin errors++; $display("FAIL basic_wr_addr[%0d]: got %h expected %h", i, (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hx, exp_q[i] + 32'h1000); end
            checks++; if (i >= wr_data_log.size() || wr_data_log[i] !== (exp_q[i] ^ DKEY)) begin errors++; $display("FAIL basic_wr_data[%0d]: got %h expected %h", i, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx, exp_q[i] ^ DKEY); end
        end
    endtask

    task automatic test_zero_size();
        do_start(32'h1000, 32'h2000, 32'd0);
        checks++; if (bus.dma_done !== 1'b1) begin errors++; $display("FAIL zero_done_t1: got %b expected 1", bus.dma_done); end
        checks++; if (bus.dma_busy !== 1'b0) begin errors++; $display("FAIL zero_busy_t1: got %b expected 0", bus.dma_busy); end
        cycles(5);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        checks++; if (busy_cyc != 0 || req_seen != 0) begin errors++; $display("FAIL zero_no_traffic: got busy %0d req %0d expected 0 0", busy_cyc, req_seen); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        wr_gnt_en = 1'b0;
        do_start(32'h0001_0000, 32'h0002_0000, 32'd64);
        cycles(20);
        checks++; if (rd_cnt != 4 || wr_cnt != 0) begin errors++; $display("FAIL bp_stall_counts: got rd %0d wr %0d expected 4 0", rd_cnt, wr_cnt); end
        checks++; if (bus.rd_req !== 1'b0 || bus.wr_req !== 1'b1) begin errors++; $display("FAIL bp_stall_reqs: got rd %b wr %b expected 0 1", bus.rd_req, bus.wr_req); end
        checks++; if (bus.wr_addr !== 32'h0002_0000 || bus.wr_wdata !== (32'h0001_0000 ^ DKEY)) begin errors++; $display("FAIL bp_stall_hold: got %h/%h expected 00020000/%h", bus.wr_addr, bus.wr_wdata, 32'h0001_0000 ^ DKEY); end
        wr_gnt_en = 1'b1;
        wait_done(200, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no done expected done within 200 cycles (%0d)", n); end
        checks++; if (max_inflight != 4) begin errors++; $display("FAIL bp_max_inflight: got %0d expected 4", max_inflight); end
        checks++; if (wr_addr_log.size() != 16 || rd_log.size() != 16) begin errors++; $display("FAIL bp_counts: got rd %0d wr %0d expected 16 16", rd_log.size(), wr_addr_log.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= wr_addr_log.size() || wr_addr_log[i] !== 32'h0002_0000 + 32'(4 * i) ||
                wr_data_log[i] !== ((32'h0001_0000 + 32'(4 * i)) ^ DKEY)) begin
                errors++;
                $display("FAIL bp_write[%0d]: got %h/%h expected %h/%h", i,
                         (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hx, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx,
                         32'h0002_0000 + 32'(4 * i), (32'h0001_0000 + 32'(4 * i)) ^ DKEY);
            end
        end
        cycles(2);
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_q[$];
        bit ok;
        int n;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_start(32'hFFFF_FFF8, 32'h3000, 32'd16);
        wait_done(100, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got no done expected done within 100 cycles (%0d)", n); end
        checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL wrap_rd_count: got %0d expected 4", rd_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= rd_log.size() || rd_log[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'hx, exp_q[i]); end
            checks++; if (i >= wr_data_log.size() || wr_data_log[i] !== (exp_q[i] ^ DKEY)) begin errors++; $display("FAIL wrap_wr_data[%0d]: got %h expected %h", i, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx, exp_q[i] ^ DKEY); end
        end
        cycles(2);
    endtask

    task automatic test_restart_and_reset();
        bit ok;
        int n;
        do_start(32'h4000, 32'h5000, 32'd64);
        cycles(2);
        bus.dma_src = 32'h8000; bus.dma_dst = 32'h9000; bus.dma_size = 32'd8;
        bus.dma_start = 1'b1;
        cycles(1);
        bus.dma_start = 1'b0;
        cycles(2);
        checks++; if (bus.dma_busy !== 1'b1) begin errors++; $display("FAIL restart_still_busy: got %b expected 1", bus.dma_busy); end
        checks++; if (rd_cnt < 1) begin errors++; $display("FAIL restart_reads_seen: got %0d expected at least 1", rd_cnt); end
        for (int i = 0; i < rd_log.size(); i++) begin
            checks++; if (rd_log[i] !== 32'h4000 + 32'(4 * i)) begin errors++; $display("FAIL restart_rd_addr[%0d]: got %h expected %h", i, rd_log[i], 32'h4000 + 32'(4 * i)); end
        end
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        checks++; if ({bus.dma_busy, bus.dma_done, bus.dma_err, bus.rd_req, bus.wr_req} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {bus.dma_busy, bus.dma_done, bus.dma_err, bus.rd_req, bus.wr_req}); end
        checks++; if ({bus.rd_addr, bus.wr_addr, bus.wr_wdata} !== 96'h0) begin errors++; $display("FAIL rst_mid_bus: got %h expected 0", {bus.rd_addr, bus.wr_addr, bus.wr_wdata}); end
        clear_logs();
        cycles(5);
        checks++; if (done_cnt != 0 || busy_cyc != 0 || req_seen != 0) begin errors++; $display("FAIL rst_mid_quiet: got done %0d busy %0d req %0d expected 0 0 0", done_cnt, busy_cyc, req_seen); end
        do_start(32'h6000, 32'h7000, 32'd8);
        wait_done(100, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL rst_new_done: got no done expected done within 100 cycles (%0d)", n); end
        checks++; if (wr_addr_log.size() != 2) begin errors++; $display("FAIL rst_new_count: got %0d expected 2", wr_addr_log.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= wr_addr_log.size() || wr_addr_log[i] !== 32'h7000 + 32'(4 * i) || wr_data_log[i] !== ((32'h6000 + 32'(4 * i)) ^ DKEY)) begin
                errors++;
                $display("FAIL rst_new_write[%0d]: got %h/%h expected %h/%h", i,
                         (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hx, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx,
                         32'h7000 + 32'(4 * i), (32'h6000 + 32'(4 * i)) ^ DKEY);
            end
        end
        cycles(2);
    endtask

    task automatic test_alignment();
`ifdef CGRA_DMA_ALIGN_CHECK_EN
        do_start(32'h1002, 32'h2000, 32'd8);
        checks++; if ({bus.dma_err, bus.dma_done, bus.dma_busy} !== 3'b110) begin errors++; $display("FAIL align_err_t1: got err/done/busy %b expected 110", {bus.dma_err, bus.dma_done, bus.dma_busy}); end
        cycles(4);
        checks++; if (err_cnt != 1 || req_seen != 0) begin errors++; $display("FAIL align_no_traffic: got err %0d req %0d expected 1 0", err_cnt, req_seen); end
`else
        bit ok;
        int n;
        do_start(32'h1002, 32'h2000, 32'd8);
        wait_done(100, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL align_done: got no done expected done within 100 cycles (%0d)", n); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL align_err_tied: got %0d expected 0", err_cnt); end
        checks++; if (rd_log.size() != 2) begin errors++; $display("FAIL align_rd_count: got %0d expected 2", rd_log.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (i >= rd_log.size() || rd_log[i] !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL align_rd_addr[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 32'hx, 32'h1000 + 32'(4 * i)); end
            checks++; if (i >= wr_data_log.size() || wr_data_log[i] !== ((32'h1000 + 32'(4 * i)) ^ DKEY)) begin errors++; $display("FAIL align_wr_data[%0d]: got %h expected %h", i, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx, (32'h1000 + 32'(4 * i)) ^ DKEY); end
        end
`endif
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_size();
        test_backpressure();
        test_addr_wrap();
        test_restart_and_reset();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgra_dma_engine.md
# cgra_dma_engine

Word-granular copy engine that consumes the static DMA configuration and start pulse from the CGRA CSR block, and reports busy/done status back to it. It moves `size` bytes from `src` to `dst` over two independent request/grant memory master ports, one for reads and one for writes. Read data is buffered in a small credit-controlled FIFO so reads and writes overlap. It sits between the CSR block and the CGRA memory interconnect.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width; bytes per word = `DATA_WIDTH/8`.
- `FIFO_DEPTH`, 4, read-data buffer entries (power of 2, ≥2); also the cap on outstanding reads.

Ports:
- Reset is `rst_n`, synchronous, active-low. The clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `dma_src`  in  ADDR_WIDTH  source byte address
- `dma_dst`  in  ADDR_WIDTH  destination byte address
- `dma_size`  in  32  transfer length in bytes
- `dma_start`  in  1  single-cycle start pulse
- `dma_busy`  out  1  transfer in progress
- `dma_done`  out  1  single-cycle completion pulse
- `dma_err`  out  1  single-cycle error pulse (alignment check only)
- `rd_req`  out  1  read request
- `rd_addr`  out  ADDR_WIDTH  read byte address
- `rd_gnt`  in  1  read request accepted
- `rd_rvalid`  in  1  read data valid, in request order
- `rd_rdata`  in  DATA_WIDTH  read data
- `wr_req`  out  1  write request
- `wr_addr`  out  ADDR_WIDTH  write byte address
- `wr_wdata`  out  DATA_WIDTH  write data
- `wr_gnt`  in  1  write accepted (write complete)

## Operation
- FSM states are IDLE, RUN, FINISH.
- IDLE → RUN: on `dma_start` with word count `N = dma_size >> log2(DATA_WIDTH/8)` > 0. On that edge, latch `src`, `dst` and `N`.
- IDLE → FINISH: on `dma_start` with N = 0. No memory traffic is issued.
- RUN → FINISH: on the cycle the N-th `wr_gnt` is seen.
- FINISH → IDLE: unconditional after one cycle.
- `dma_start` in RUN or FINISH is ignored. The latched config is never changed mid-transfer.
- Sub-word remainder bytes (`dma_size` low bits) are dropped.
- Reads: `rd_req` is asserted while `reads_issued < N` and `outstanding + fifo_count < FIFO_DEPTH`.
  - `outstanding` is granted reads minus rvalids received.
  - `rd_addr` increments by the word size on each `rd_gnt`. It wraps modulo 2^ADDR_WIDTH.
- Every `rd_rvalid` in RUN pushes into the FIFO. Overflow is impossible by credit.
- Writes: `wr_req` is asserted while the FIFO is non-empty. `wr_wdata` is the FIFO head.
  - A pop happens on `wr_gnt`.
  - `wr_addr` increments by the word size on each `wr_gnt`, with the same wrap rule.
- Simultaneous push and pop on the same cycle is legal; the count is unchanged.
- `rd_rvalid` and `wr_gnt` in IDLE or FINISH are ignored.
- Reset mid-transfer: immediate return to IDLE. Counters and FIFO are cleared and all outputs go to their reset values. The interconnect is reset together with this block.

## Timing
- Reset values: `dma_busy`, `dma_done`, `dma_err`, `rd_req`, `wr_req` are 0. `rd_addr`, `wr_addr`, `wr_wdata` are 0.
- Start sampled at edge T:
  - `dma_busy` = 1 from T+1.
  - First `rd_req` is at T+1.
- Request hold: `rd_req`/`wr_req` stay high with stable addr/data until granted.
- Back-to-back: the next request may assert in the cycle after a grant; one grant per cycle maximum.
- Read-to-write: the first `wr_req` comes one cycle after the `rd_rvalid` that makes the FIFO non-empty.
- Completion: final `wr_gnt` at edge F.
  - `dma_done` is high during F+1 only.
  - `dma_busy` falls at F+1.
- Zero size: `dma_done` pulses at T+1. `dma_busy` stays 0.
- Minimum start-to-start spacing is 2 cycles after done.

## Configuration
- `CGRA_DMA_ALIGN_CHECK_EN` defined:
  - Start with `dma_src`, `dma_dst` or `dma_size` not word-aligned → IDLE → FINISH with no traffic.
  - `dma_err` and `dma_done` both pulse at T+1.
- `CGRA_DMA_ALIGN_CHECK_EN` undefined:
  - Address low bits are forced to zero and size remainder is dropped.
  - `dma_err` is tied 0.

## Structure
- `cgra_dma_pkg` holds:
  - the state enum `dma_state_e` (IDLE, RUN, FINISH);
  - `BYTES_PER_WORD` and `WORD_SHIFT` localparams derived from the default width;
  - a packed config struct (src, dst, nwords).
- One sub-module, `cgra_dma_fifo`: synchronous FIFO with depth `FIFO_DEPTH` and width `DATA_WIDTH`.
  - Outputs: count, empty, full, first-word-fall-through head.
  - Clears on `rst_n`.

## Test plan
- src=0x1000, dst=0x2000, size=16, memory always grants, rvalid 1 cycle after grant → 4 reads at 0x1000..0x100C and 4 writes at 0x2000..0x200C with matching data; one `dma_done` pulse; busy for the exact duration.
- size=0 → `dma_done` at T+1, `dma_busy` never 1, no `rd_req`/`wr_req`.
- size=64, `wr_gnt` held low 20 cycles → at most 4 outstanding plus buffered reads; no data lost; completes after release.
- src=0xFFFFFFF8, size=16 → `rd_addr` sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- `dma_start` re-pulsed mid-RUN, then `rst_n` low for 1 cycle mid-transfer → second start ignored; after reset all outputs are 0, no done pulse, and a new start works.
- With `CGRA_DMA_ALIGN_CHECK_EN`, src=0x1002 → `dma_err` and `dma_done` at T+1, no traffic; without it → copy from 0x1000.
